// File: rtl/reset_sequencer.sv
// Staged reset generator. Synchronised, edge-qualified reset requests start a
// PULSE_LEN pulse. An optional hold follows, then rst_out bits release STAGE_GAP cycles apart.
module reset_sequencer #(
    parameter int                 NUM_SRC   = 4,
    parameter int                 NUM_OUT   = 3,
    parameter int                 PULSE_LEN = 16,
    parameter int                 STAGE_GAP = 4,
    parameter logic [NUM_SRC-1:0] EDGE_POL  = 4'b1101
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_in,
    input  logic [NUM_SRC-1:0] src_enable,
    input  logic               hold_req,
    input  logic               release_req,
    input  logic               cause_clear,
    output logic [NUM_OUT-1:0] rst_out,
    output logic               busy,
    output logic [NUM_SRC:0]   cause
);
    localparam logic [1:0] ST_ASSERT  = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_RUN     = 2'd3;

    localparam int CNT_MAX = (PULSE_LEN > STAGE_GAP) ? PULSE_LEN : STAGE_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]   PULSE_LAST = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST   = CNT_W'(STAGE_GAP - 1);
    localparam logic [NUM_OUT-1:0] ALL_ON     = '1;
    localparam logic [NUM_OUT-1:0] FIRST_REL  = ALL_ON << 1;
    // A single-output sequencer has nothing left to stage after the first release.
    localparam logic [1:0]         REL_TARGET = (NUM_OUT == 1) ? ST_RUN : ST_RELEASE;

    logic [NUM_SRC-1:0] r_s1;
    logic [NUM_SRC-1:0] r_s2;
    logic [NUM_SRC-1:0] r_p;
    logic [1:0]         r_arm_cnt;
    logic               r_rel_prev;
    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_OUT-1:0] r_rst_out;
    logic               r_busy;
    logic [NUM_SRC:0]   r_cause;

    logic [NUM_SRC-1:0] w_trig;
    logic [NUM_SRC-1:0] w_trig_acc;
    logic               w_armed;
    logic               w_any_trig;
    logic               w_rel_rise;
    logic [NUM_OUT-1:0] w_rst_shift;
    logic [1:0]         w_state_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [NUM_OUT-1:0] w_rst_next;
    logic [NUM_SRC:0]   w_cause_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_trig
            if (EDGE_POL[gi]) begin : g_rise
                assign w_trig[gi] = src_enable[gi] & r_s2[gi] & ~r_p[gi];
            end else begin : g_fall
                assign w_trig[gi] = src_enable[gi] & ~r_s2[gi] & r_p[gi];
            end
        end
    endgenerate

    // Synchroniser contents right after reset can fake an edge, so hold off three edges.
    assign w_armed      = (r_arm_cnt == 2'd3);
    assign w_trig_acc   = w_armed ? w_trig : '0;
    assign w_any_trig   = |w_trig_acc;
    assign w_rel_rise   = release_req & ~r_rel_prev;
    assign w_rst_shift  = r_rst_out << 1;
    assign w_cause_next = (cause_clear ? '0 : r_cause) | {1'b0, w_trig_acc};

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_rst_next   = r_rst_out;
        case (r_state)
            ST_ASSERT: begin
                w_rst_next = ALL_ON;
                if (w_any_trig) begin
                    w_cnt_next = '0;
                end else if (r_cnt == PULSE_LAST) begin
                    w_cnt_next = '0;
                    if (hold_req) begin
                        w_state_next = ST_HOLD;
                    end else begin
                        w_rst_next   = FIRST_REL;
                        w_state_next = REL_TARGET;
                    end
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                w_rst_next = ALL_ON;
                w_cnt_next = '0;
                if (!w_any_trig && w_rel_rise) begin
                    w_rst_next   = FIRST_REL;
                    w_state_next = REL_TARGET;
                end
            end
            ST_RELEASE: begin
                if (w_any_trig) begin
                    w_rst_next   = ALL_ON;
                    w_cnt_next   = '0;
                    w_state_next = ST_ASSERT;
                end else if (r_cnt == GAP_LAST) begin
                    w_cnt_next = '0;
                    w_rst_next = w_rst_shift;
                    if (w_rst_shift == '0) begin
                        w_state_next = ST_RUN;
                    end
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            ST_RUN: begin
                w_rst_next = '0;
                w_cnt_next = '0;
                if (w_any_trig) begin
                    w_rst_next   = ALL_ON;
                    w_state_next = ST_ASSERT;
                end
            end
            default: begin
                w_state_next = ST_ASSERT;
                w_rst_next   = ALL_ON;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_s1       <= '0;
            r_s2       <= '0;
            r_p        <= '0;
            r_arm_cnt  <= 2'd0;
            r_rel_prev <= 1'b0;
            r_state    <= ST_ASSERT;
            r_cnt      <= '0;
            r_rst_out  <= ALL_ON;
            r_busy     <= 1'b1;
            r_cause    <= {1'b1, {NUM_SRC{1'b0}}};
        end else begin
            r_s1       <= src_in;
            r_s2       <= r_s1;
            r_p        <= r_s2;
            if (!w_armed) begin
                r_arm_cnt <= r_arm_cnt + 2'd1;
            end
            r_rel_prev <= release_req;
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_rst_out  <= w_rst_next;
            r_busy     <= |w_rst_next;
            r_cause    <= w_cause_next;
        end
    end

    assign rst_out = r_rst_out;
    assign busy    = r_busy;
    assign cause   = r_cause;
endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a timestamp-based model of pulse start and release edges,
// directed scenarios pinned by literal expectations, then randomized traffic.
module tb_reset_sequencer;
    localparam int NS = 4;
    localparam int NO = 3;
    localparam int PL = 16;
    localparam int SG = 4;
    localparam logic [NS-1:0] POL = 4'b1101;

    logic          clk_sys;
    logic          reset;
    logic [NS-1:0] src_in;
    logic [NS-1:0] src_enable;
    logic          hold_req;
    logic          release_req;
    logic          cause_clear;
    logic [NO-1:0] rst_out;
    logic          busy;
    logic [NS:0]   cause;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: edge index since reset dropped, edge the current pulse began,
    // edge of the first release (-1 while fully asserted), and a hold flag.
    int            m_edge  = 0;
    int            m_start = 0;
    int            m_rel   = -1;
    bit            m_hold  = 0;
    bit            m_valid = 0;
    bit            m_rel_prev = 0;
    logic [NS-1:0] m_smp [1:3];
    logic [NO-1:0] m_rst;
    logic [NS:0]   m_cause;

    reset_sequencer #(
        .NUM_SRC(NS), .NUM_OUT(NO), .PULSE_LEN(PL), .STAGE_GAP(SG), .EDGE_POL(POL)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .src_in(src_in), .src_enable(src_enable),
        .hold_req(hold_req), .release_req(release_req), .cause_clear(cause_clear),
        .rst_out(rst_out), .busy(busy), .cause(cause)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    task automatic model_step();
        logic [NS-1:0] trig;
        bit rise;
        // A request sampled two and three edges ago forms the edge seen now.
        for (int i = 0; i < NS; i++) begin
            trig[i] = src_enable[i] & (POL[i] ? (m_smp[2][i] & ~m_smp[3][i])
                                              : (~m_smp[2][i] & m_smp[3][i]));
        end
        if (reset) begin
            m_edge = 0; m_start = 0; m_rel = -1; m_hold = 0; m_rel_prev = 0;
            m_cause = '0;
            m_cause[NS] = 1'b1;
            for (int i = 1; i <= 3; i++) m_smp[i] = '0;
        end else begin
            m_edge++;
            if (m_edge < 4) trig = '0;
            rise = release_req & ~m_rel_prev;
            m_rel_prev = release_req;
            m_cause = (cause_clear ? '0 : m_cause) | {1'b0, trig};
            if (m_hold) begin
                if (trig == '0 && rise) begin
                    m_hold = 0;
                    m_rel = m_edge;
                end
            end else if (trig != '0) begin
                m_start = m_edge;
                m_rel = -1;
            end else if (m_rel < 0 && (m_edge - m_start) == PL) begin
                if (hold_req) m_hold = 1;
                else m_rel = m_edge;
            end
            m_smp[3] = m_smp[2];
            m_smp[2] = m_smp[1];
            m_smp[1] = src_in;
        end
        for (int i = 0; i < NO; i++) m_rst[i] = (m_rel < 0) || (m_edge < m_rel + i * SG);
        m_valid = 1;
    endtask

    initial begin
        forever begin
            @(posedge clk_sys);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk_sys);
            if (m_valid) begin
                n_checks++;
                if (rst_out !== m_rst || busy !== (|m_rst) || cause !== m_cause) begin
                    n_errors++;
                    $display("FAIL cycle_cmp edge=%0d rst_out=%b req=%b busy=%b req=%b cause=%b req=%b",
                             m_edge, rst_out, m_rst, busy, |m_rst, cause, m_cause);
                end
            end
        end
    end

    task automatic goto_neg(input int n);
        int k;
        k = 0;
        while (m_edge != n && k < 300) begin
            @(negedge clk_sys);
            k++;
        end
        if (m_edge != n) begin
            n_checks++;
            n_errors++;
            $display("FAIL timeout edge=%0d required=%0d", m_edge, n);
        end
    endtask

    task automatic expect_at(input string nm, input int n, input logic [NO-1:0] er,
                             input logic [NS:0] ec);
        goto_neg(n);
        n_checks++;
        if (rst_out !== er || busy !== (|er) || cause !== ec || m_rst !== er || m_cause !== ec) begin
            n_errors++;
            $display("FAIL %s edge=%0d rst_out=%b model=%b req=%b busy=%b cause=%b model=%b req=%b",
                     nm, m_edge, rst_out, m_rst, er, busy, cause, m_cause, ec);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_sys);
        reset = 1'b1;
        repeat (5) @(negedge clk_sys);
        reset = 1'b0;
    endtask

    initial begin
        int rate;
        reset = 1'b1; src_in = '0; src_enable = '1;
        hold_req = 1'b0; release_req = 1'b0; cause_clear = 1'b0;

        // Power-on sequence, then a rising request on source 0 in RUN.
        do_reset();
        expect_at("por_e15", 15, 3'b111, 5'b10000);
        expect_at("por_e16", 16, 3'b110, 5'b10000);
        expect_at("por_e19", 19, 3'b110, 5'b10000);
        expect_at("por_e20", 20, 3'b100, 5'b10000);
        expect_at("por_e23", 23, 3'b100, 5'b10000);
        expect_at("por_e24", 24, 3'b000, 5'b10000);
        goto_neg(39);
        src_in[0] = 1'b1;
        expect_at("src0_e41", 41, 3'b000, 5'b10000);
        expect_at("src0_e42", 42, 3'b111, 5'b10001);
        expect_at("src0_e57", 57, 3'b111, 5'b10001);
        expect_at("src0_e58", 58, 3'b110, 5'b10001);
        expect_at("src0_e62", 62, 3'b100, 5'b10001);
        expect_at("src0_e66", 66, 3'b000, 5'b10001);
        src_in[0] = 1'b0;

        // Retrigger during RELEASE.
        do_reset();
        goto_neg(15);
        src_in[3] = 1'b1;
        expect_at("retrig_e17", 17, 3'b110, 5'b10000);
        expect_at("retrig_e18", 18, 3'b111, 5'b11000);
        expect_at("retrig_e33", 33, 3'b111, 5'b11000);
        expect_at("retrig_e34", 34, 3'b110, 5'b11000);
        src_in[3] = 1'b0;

        // Hold then release.
        do_reset();
        goto_neg(15);
        hold_req = 1'b1;
        expect_at("hold_e16", 16, 3'b111, 5'b10000);
        hold_req = 1'b0;
        goto_neg(49);
        expect_at("hold_e49", 49, 3'b111, 5'b10000);
        release_req = 1'b1;
        expect_at("hold_e50", 50, 3'b110, 5'b10000);
        release_req = 1'b0;
        expect_at("hold_e53", 53, 3'b110, 5'b10000);
        expect_at("hold_e54", 54, 3'b100, 5'b10000);
        expect_at("hold_e58", 58, 3'b000, 5'b10000);

        // Masking, falling polarity and clear-versus-set priority.
        src_enable = 4'b1011;
        do_reset();
        goto_neg(29);
        src_in[1] = 1'b1;
        src_in[2] = 1'b1;
        expect_at("mask_e35", 35, 3'b000, 5'b10000);
        goto_neg(39);
        src_in[1] = 1'b0;
        expect_at("fall_e41", 41, 3'b000, 5'b10000);
        expect_at("fall_e42", 42, 3'b111, 5'b10010);
        goto_neg(69);
        src_in[1] = 1'b1;
        goto_neg(79);
        src_in[1] = 1'b0;
        goto_neg(81);
        cause_clear = 1'b1;
        expect_at("clr_set_e82", 82, 3'b111, 5'b00010);
        cause_clear = 1'b0;
        goto_neg(89);
        cause_clear = 1'b1;
        expect_at("clr_e90", 90, 3'b111, 5'b00000);
        cause_clear = 1'b0;
        src_in = '0;
        src_enable = '1;

        // Request held high through reset must not fire; then reset mid-RELEASE.
        src_in[0] = 1'b1;
        do_reset();
        expect_at("arm_e3", 3, 3'b111, 5'b10000);
        expect_at("arm_e16", 16, 3'b110, 5'b10000);
        expect_at("arm_e18", 18, 3'b110, 5'b10000);
        reset = 1'b1;
        @(negedge clk_sys);
        expect_at("midrel_rst", 0, 3'b111, 5'b10000);
        @(negedge clk_sys);
        reset = 1'b0;
        expect_at("midrel_e15", 15, 3'b111, 5'b10000);
        expect_at("midrel_e16", 16, 3'b110, 5'b10000);
        expect_at("arm_e24", 24, 3'b000, 5'b10000);
        src_in = '0;

        // Randomized traffic, alternating busy and quiet request rates.
        do_reset();
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk_sys);
            rate = ((c / 500) % 2 == 1) ? 200 : 40;
            for (int b = 0; b < NS; b++) begin
                if ($urandom_range(0, rate - 1) == 0) src_in[b] = ~src_in[b];
            end
            if ($urandom_range(0, 99) == 0) src_enable = 4'($urandom);
            hold_req    = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 5) == 0) release_req = ~release_req;
            cause_clear = ($urandom_range(0, 29) == 0);
            reset       = ($urandom_range(0, 399) == 0);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk_sys);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4: number of reset-request sources.
REQ-002 SHALL have parameter NUM_OUT, default 3: number of staged reset outputs.
REQ-003 SHALL have parameter PULSE_LEN, default 16: cycles all outputs stay asserted; legal range >=1.
REQ-004 SHALL have parameter STAGE_GAP, default 4: cycles between successive output releases; legal range >=1.
REQ-005 SHALL have parameter EDGE_POL, default 4'b1101, NUM_SRC bits: per-source trigger edge, 1 = rising, 0 = falling.
REQ-006 SHALL have port clk_sys  in  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have port src_in  in  NUM_SRC  asynchronous reset-request lines (buttons, upload strobe, ...).
REQ-009 SHALL have port src_enable  in  NUM_SRC  synchronous per-source accept mask.
REQ-010 SHALL have port hold_req  in  1  synchronous; keep outputs asserted after the pulse until release.
REQ-011 SHALL have port release_req  in  1  synchronous; rising edge leaves HOLD.
REQ-012 SHALL have port cause_clear  in  1  synchronous; clears cause.
REQ-013 SHALL have port rst_out  out  NUM_OUT  active-high resets; bit 0 released first.
REQ-014 SHALL have port busy  out  1  high while any rst_out bit is high.
REQ-015 SHALL have port cause  out  NUM_SRC+1  sticky trigger record; bit NUM_SRC = reset/power-on.

Function
REQ-016 Each src_in bit SHALL pass a 2-flop synchroniser (s1, s2) followed by a previous-value flop p; trigger[i] = src_enable[i] & (EDGE_POL[i] ? s2&~p : ~s2&p).
REQ-017 Triggers SHALL be ignored for the first 3 clk_sys edges after reset deasserts (arm window); s1/s2/p keep updating during it.
REQ-018 FSM states SHALL be ASSERT, HOLD, RELEASE, RUN; all outputs registered.
REQ-019 ASSERT: rst_out all ones; cycle counter increments; on the PULSE_LEN-th edge in ASSERT, go to HOLD if hold_req=1 at that edge, else go to RELEASE and clear rst_out[0] on that same edge.
REQ-020 RELEASE: rst_out[i] SHALL clear exactly STAGE_GAP edges after rst_out[i-1]; when rst_out[NUM_OUT-1] clears, go to RUN on that same edge.
REQ-021 With NUM_OUT=1, the transition ASSERT -> RUN SHALL occur directly on the PULSE_LEN-th edge.
REQ-022 HOLD: rst_out all ones; on a release_req rising edge (one-flop detect), go to RELEASE, clearing rst_out[0] on that edge.
REQ-023 RUN: rst_out all zero; busy=0.
REQ-024 Any trigger in RUN, RELEASE or ASSERT SHALL, on the edge it is seen, set rst_out to all ones, zero the counter, and enter ASSERT (retrigger extends the pulse).
REQ-025 A trigger in HOLD SHALL stay in HOLD and only update cause.
REQ-026 Latency: a src_in change sampled on edge k SHALL produce rst_out all ones from edge k+2.
REQ-027 cause[i] SHALL be set on every accepted trigger[i]; cause_clear zeroes all bits; a simultaneous set wins over clear for that bit.
REQ-028 busy SHALL equal |rst_out at every cycle.
REQ-029 Counter width SHALL be $clog2(max(PULSE_LEN, STAGE_GAP)+1); no wrap within a state.

Reset
REQ-030 While reset=1: state ASSERT, counter 0, rst_out all ones, busy=1, cause = only bit NUM_SRC set, s1/s2/p = 0, arm window restarted.
REQ-031 Reset asserted mid-RELEASE or mid-HOLD SHALL reassert all rst_out on that edge; after reset drops, a full PULSE_LEN pulse SHALL follow.

Verification (defaults; edge 1 = first edge with reset=0)
REQ-032 Power-on: reset 1 for 5 cycles, then 0 -> rst_out 3'b111 through edge 15; rst_out[0] falls at edge 16, [1] at edge 20, [2] at edge 24; busy falls at edge 24; cause=5'b10000.
REQ-033 src_in[0] rises at a clock edge sampled on edge 40 in RUN -> rst_out=3'b111 from edge 42; release at 58/62/66; cause[0]=1.
REQ-034 Retrigger: src_in[3] rising seen in RELEASE at edge 18 -> rst_out=3'b111 at edge 18; rst_out[0] falls at edge 34.
REQ-035 Hold: hold_req=1 at edge 16 -> rst_out stays 3'b111; release_req rising seen at edge 50 -> rst_out[0]=0 at 50, [1] at 54, [2] at 58.
REQ-036 Masking/polarity: src_in[1] rising, or src_enable[2]=0 with src_in[2] rising -> no reset; src_in[1] falling -> reset, cause[1]=1; cause_clear coincident with new trigger[1] -> cause[1] stays 1.
REQ-037 Arm window: src_in[0]=1 held through reset -> no trigger after reset release; rst_out released at 16/20/24.
